// File: rtl/mode1_stream_ctrl_pkg.sv
// Shared constants and FSM state type for the mode-1 (row max) softmax read controller.
package mode1_stream_ctrl_pkg;

    localparam int          DEF_DATAWIDTH = 16;
    localparam int          DEF_LANES     = 8;
    localparam logic [15:0] NEG_INF       = 16'hFC00;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        DRAIN,
        DONE
    } mode1_state_e;

endpackage

// File: rtl/mode1_lane_pad.sv
// Lane pad mux: in the last word of a partial row, lanes at or above tail are replaced by -inf
// so that stale SRAM contents cannot win the max.
module mode1_lane_pad
    import mode1_stream_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int TAILW     = $clog2(DEF_LANES)
) (
    input  logic [LANES*DATAWIDTH-1:0] i_data,
    input  logic                       i_lastWord,
    input  logic [TAILW-1:0]           i_tail,
    output logic [LANES*DATAWIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        for (int l = 0; l < LANES; l++) begin
            if (i_lastWord && (i_tail != '0) && (l >= int'(i_tail))) begin
                o_data[l*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(NEG_INF);
            end
        end
    end

endmodule

// File: rtl/mode1_stream_ctrl.sv
// Mode-1 (row max) read controller: streams one row from SRAM into the max tree, drains it, captures the max.
// Build option MODE1_PAD_EN: pad the unused lanes of a partial last word with -inf (otherwise rows must be whole words).
module mode1_stream_ctrl
    import mode1_stream_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int ADDRW     = 10,
    parameter int LENW      = 16,
    parameter int RD_LAT    = 1,
    parameter int TREE_LAT  = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ADDRW-1:0]           base_addr,
    input  logic [LENW-1:0]            num_elems,
    output logic                       busy,
    output logic                       done,
    output logic [DATAWIDTH-1:0]       max_out,
    output logic                       rd_en,
    output logic [ADDRW-1:0]           rd_addr,
    input  logic [LANES*DATAWIDTH-1:0] rd_data,
    output logic                       tree_reset,
    output logic                       tree_run,
    output logic [LANES*DATAWIDTH-1:0] tree_inp,
    input  logic [DATAWIDTH-1:0]       tree_outp
);

    localparam int                TAILW      = $clog2(LANES);
    localparam int                DRAINW     = 8;
    localparam logic [DRAINW-1:0] DRAIN_LOAD = DRAINW'(RD_LAT + TREE_LAT - 1);

    mode1_state_e      r_state;
    logic              r_armed;
    logic [LENW-1:0]   r_wordsLeft;
    logic [DRAINW-1:0] r_drainCnt;
    logic [RD_LAT-1:0] r_runSr;
    logic              w_accept;
    logic [LENW-1:0]   w_words;

    assign w_words  = (num_elems >> TAILW) + LENW'(|num_elems[TAILW-1:0]);
    // r_armed keeps a start that coincides with reset release from being taken.
    assign w_accept = start && r_armed && (r_state == IDLE);
    assign tree_run = r_runSr[RD_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_wordsLeft <= '0;
            r_drainCnt  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            max_out     <= '0;
            tree_reset  <= 1'b1;
        end else begin
            r_armed <= 1'b1;
            done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    tree_reset <= 1'b0;
                    if (w_accept) begin
                        r_state     <= CLEAR;
                        busy        <= 1'b1;
                        tree_reset  <= 1'b1;
                        rd_addr     <= base_addr;
                        r_wordsLeft <= w_words;
                    end
                end
                CLEAR: begin
                    tree_reset <= 1'b0;
                    if (r_wordsLeft != '0) begin
                        r_state <= READ;
                        rd_en   <= 1'b1;
                    end else begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        max_out <= '0;
                    end
                end
                READ: begin
                    r_wordsLeft <= r_wordsLeft - LENW'(1);
                    if (r_wordsLeft == LENW'(1)) begin
                        rd_en      <= 1'b0;
                        r_state    <= DRAIN;
                        r_drainCnt <= DRAIN_LOAD;
                    end else begin
                        rd_addr <= rd_addr + ADDRW'(1);
                    end
                end
                DRAIN: begin
                    if (r_drainCnt == '0) begin
                        max_out <= tree_outp;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_drainCnt <= r_drainCnt - DRAINW'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_runSr <= '0;
        end else begin
            r_runSr <= (r_runSr << 1) | RD_LAT'(rd_en);
        end
    end

`ifdef MODE1_PAD_EN
    logic [RD_LAT-1:0] r_lastSr;
    logic [TAILW-1:0]  r_tail;

    // The last-word flag rides alongside rd_en so it lines up with the returning SRAM word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lastSr <= '0;
            r_tail   <= '0;
        end else begin
            if (w_accept) begin
                r_tail <= num_elems[TAILW-1:0];
            end
            r_lastSr <= (r_lastSr << 1) | RD_LAT'(rd_en && (r_wordsLeft == LENW'(1)));
        end
    end

    mode1_lane_pad #(
        .DATAWIDTH (DATAWIDTH),
        .LANES     (LANES),
        .TAILW     (TAILW)
    ) u_lanePad (
        .i_data     (rd_data),
        .i_lastWord (r_lastSr[RD_LAT-1]),
        .i_tail     (r_tail),
        .o_data     (tree_inp)
    );
`else
    assign tree_inp = rd_data;
`endif

endmodule
